// File: rtl/pri_encoder_hs.sv
// Registered priority encoder with sticky pending bits, valid/ack grant handshake and EI/EO cascade.
// Optional per-channel request mask enabled by defining PRI_ENCODER_HS_MASK_EN.
module pri_encoder_hs #(
  parameter int unsigned N         = 8,
  parameter int unsigned RR_MODE   = 0,
  parameter int unsigned EDGE_MODE = 0
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic [N-1:0]         iReq,
  input  logic                 iEI_n,
  input  logic                 iAck,
`ifdef PRI_ENCODER_HS_MASK_EN
  input  logic [N-1:0]         iMask,
`endif
  output logic                 oValid,
  output logic [$clog2(N)-1:0] oIdx,
  output logic                 oGS_n,
  output logic                 oEO_n
);

  localparam int unsigned IdW = $clog2(N);

  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   req_q;
  logic           valid_q, valid_d;
  logic [IdW-1:0] idx_q, idx_d;
  logic [IdW-1:0] ptr_q, ptr_d;

  logic [N-1:0]   cap;
  logic [N-1:0]   clr;
  logic [N-1:0]   mask;
  logic [N-1:0]   elig;
  logic           load;
  logic [IdW-1:0] win_fix, win_lo, win;
  logic           any_lo;

`ifdef PRI_ENCODER_HS_MASK_EN
  assign mask = iMask;
`else
  assign mask = '0;
`endif

  always_comb begin
    cap = (EDGE_MODE != 0) ? (iReq & ~req_q) : iReq;
    clr = '0;
    if (valid_q && iAck) clr[idx_q] = 1'b1;
    elig = pending_q & ~clr & ~mask;
    // Set beats clear when a channel re-requests in the cycle its grant is acked.
    pending_d = (pending_q & ~clr) | (iEI_n ? '0 : cap);
    load = !iEI_n && (!valid_q || iAck) && (|elig);
  end

  // Round-robin descends from ptr-1 with wrap: take the highest eligible index
  // below the pointer, else fall back to the highest eligible index overall.
  always_comb begin
    win_fix = '0;
    win_lo  = '0;
    any_lo  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (elig[i]) win_fix = IdW'(i);
      if (elig[i] && (IdW'(i) < ptr_q)) begin
        win_lo = IdW'(i);
        any_lo = 1'b1;
      end
    end
    win = ((RR_MODE != 0) && any_lo) ? win_lo : win_fix;
  end

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = 1'b1;
      idx_d   = win;
      ptr_d   = win;
    end else if (valid_q && iAck) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      pending_q <= '0;
      req_q     <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      ptr_q     <= '0;
    end else begin
      pending_q <= pending_d;
      req_q     <= iReq;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
    end
  end

  assign oValid = valid_q;
  assign oIdx   = idx_q;
  assign oGS_n  = iEI_n | ~valid_q;
  // Registered state only, so a cascade never sees a path from iReq or iAck.
  assign oEO_n  = !(!iEI_n && !valid_q && !(|(pending_q & ~mask)));

endmodule

// File: tb/tb_pri_encoder_hs.sv
// Directed bench for pri_encoder_hs: fixed/level, round-robin and edge-capture instances.
module tb_pri_encoder_hs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_f, req_r, req_e;
  logic       ack_f, ack_r, ack_e;
  logic       ei_f, ei_r, ei_e;
  logic       valid_f, valid_r, valid_e;
  logic [2:0] idx_f, idx_r, idx_e;
  logic       gs_f, gs_r, gs_e;
  logic       eo_f, eo_r, eo_e;
`ifdef PRI_ENCODER_HS_MASK_EN
  logic [7:0] mask_f;
  logic [7:0] mask_zero = '0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int grants;

  always #5 clk = ~clk;

  pri_encoder_hs #(.N(8), .RR_MODE(0), .EDGE_MODE(0)) u_fix (
    .iClk(clk), .iRst_n(rst_n), .iReq(req_f), .iEI_n(ei_f), .iAck(ack_f),
`ifdef PRI_ENCODER_HS_MASK_EN
    .iMask(mask_f),
`endif
    .oValid(valid_f), .oIdx(idx_f), .oGS_n(gs_f), .oEO_n(eo_f)
  );

  pri_encoder_hs #(.N(8), .RR_MODE(1), .EDGE_MODE(0)) u_rr (
    .iClk(clk), .iRst_n(rst_n), .iReq(req_r), .iEI_n(ei_r), .iAck(ack_r),
`ifdef PRI_ENCODER_HS_MASK_EN
    .iMask(mask_zero),
`endif
    .oValid(valid_r), .oIdx(idx_r), .oGS_n(gs_r), .oEO_n(eo_r)
  );

  pri_encoder_hs #(.N(8), .RR_MODE(0), .EDGE_MODE(1)) u_edg (
    .iClk(clk), .iRst_n(rst_n), .iReq(req_e), .iEI_n(ei_e), .iAck(ack_e),
`ifdef PRI_ENCODER_HS_MASK_EN
    .iMask(mask_zero),
`endif
    .oValid(valid_e), .oIdx(idx_e), .oGS_n(gs_e), .oEO_n(eo_e)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_f = 8'hFF; ack_f = 1'b0; ei_f = 1'b0;
    req_r = 8'h00; ack_r = 1'b0; ei_r = 1'b0;
    req_e = 8'h00; ack_e = 1'b0; ei_e = 1'b0;
`ifdef PRI_ENCODER_HS_MASK_EN
    mask_f = '0;
`endif
    #1;
    tick();
    tick();
    check("rst_valid", {31'd0, valid_f}, 32'd0);
    check("rst_idx",   {29'd0, idx_f},   32'd0);
    check("rst_gs",    {31'd0, gs_f},    32'd1);

    // Requests held through reset appear two edges after release.
    rst_n = 1'b1;
    tick();
    check("rel_valid_1", {31'd0, valid_f}, 32'd0);
    tick();
    check("rel_valid_2", {31'd0, valid_f}, 32'd1);
    check("rel_idx_2",   {29'd0, idx_f},   32'd7);
    check("rel_gs_2",    {31'd0, gs_f},    32'd0);

    // Reset mid-handshake.
    ack_f = 1'b1;
    req_f = 8'h00;
    do_reset();
    ack_f = 1'b0;
    check("midrst_valid", {31'd0, valid_f}, 32'd0);

    // Fixed priority, one-cycle pulse of channels 5 and 2.
    req_f = 8'b0010_0100;
    tick();
    req_f = 8'h00;
    tick();
    check("fix_idx5",   {29'd0, idx_f},   32'd5);
    check("fix_valid5", {31'd0, valid_f}, 32'd1);
    ack_f = 1'b1;
    tick();
    check("fix_idx2",   {29'd0, idx_f},   32'd2);
    check("fix_valid2", {31'd0, valid_f}, 32'd1);
    tick();
    ack_f = 1'b0;
    check("fix_drop",  {31'd0, valid_f}, 32'd0);
    check("fix_eo",    {31'd0, eo_f},    32'd0);
    check("fix_gs",    {31'd0, gs_f},    32'd1);

    // Level mode: ack while request held -> set wins, channel regranted.
    req_f = 8'h08;
    tick();
    tick();
    check("lvl_idx3", {29'd0, idx_f}, 32'd3);
    ack_f = 1'b1;
    tick();
    check("lvl_gap", {31'd0, valid_f}, 32'd0);
    ack_f = 1'b0;
    tick();
    check("lvl_regrant_v", {31'd0, valid_f}, 32'd1);
    check("lvl_regrant_i", {29'd0, idx_f},   32'd3);
    req_f = 8'h00;
    ack_f = 1'b1;
    tick();
    ack_f = 1'b0;
    check("lvl_done", {31'd0, valid_f}, 32'd0);

    // Enable-in high holds pending without granting.
    req_f = 8'h40;
    tick();
    req_f = 8'h00;
    ei_f  = 1'b1;
    check("en_gs_off", {31'd0, gs_f}, 32'd1);
    check("en_eo_off", {31'd0, eo_f}, 32'd1);
    tick();
    tick();
    tick();
    check("en_hold_v", {31'd0, valid_f}, 32'd0);
    ei_f = 1'b0;
    check("en_eo_pend", {31'd0, eo_f}, 32'd1);
    tick();
    check("en_valid6", {31'd0, valid_f}, 32'd1);
    check("en_idx6",   {29'd0, idx_f},   32'd6);
    check("en_gs_on",  {31'd0, gs_f},    32'd0);
    ack_f = 1'b1;
    tick();
    ack_f = 1'b0;
    check("en_drop", {31'd0, valid_f}, 32'd0);

`ifdef PRI_ENCODER_HS_MASK_EN
    mask_f = 8'h80;
    req_f  = 8'h82;
    tick();
    req_f = 8'h00;
    tick();
    check("msk_idx1", {29'd0, idx_f}, 32'd1);
    ack_f  = 1'b1;
    mask_f = 8'h00;
    tick();
    ack_f = 1'b0;
    check("msk_valid7", {31'd0, valid_f}, 32'd1);
    check("msk_idx7",   {29'd0, idx_f},   32'd7);
`endif

    // Round-robin with all requests held and ack every cycle.
    do_reset();
    req_r = 8'hFF;
    tick();
    tick();
    ack_r = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("rr_valid_%0d", i), {31'd0, valid_r}, 32'd1);
      check($sformatf("rr_idx_%0d", i), {29'd0, idx_r}, 32'((15 - i) % 8));
      tick();
    end
    ack_r = 1'b0;
    req_r = 8'h00;

    // Edge capture: a held request yields exactly one grant.
    do_reset();
    req_e  = 8'h08;
    ack_e  = 1'b1;
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid_e) begin
        grants++;
        check("edge_idx", {29'd0, idx_e}, 32'd3);
      end
    end
    check("edge_grants", 32'(grants), 32'd1);
    req_e = 8'h00;
    ack_e = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
